// File: rtl/kernel_job_dispatcher.sv
// Kernel job dispatcher: hands descriptors to idle kernels, queues completions.
// Define KJD_ROUND_ROBIN_EN for round-robin kernel selection (default: fixed priority).
module kernel_job_dispatcher #(
    parameter int KERNEL_NUM = 8,
    parameter int DSC_WIDTH  = 1024,
    parameter int PID_WIDTH  = 9,
    parameter int KID_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  engine_start,
    input  logic [DSC_WIDTH-1:0]  system_register,
    output logic                  new_dsc,
    output logic [KERNEL_NUM-1:0] kernel_start,
    output logic [DSC_WIDTH-1:0]  kernel_dsc,
    input  logic [KERNEL_NUM-1:0] kernel_done,
    output logic                  cmpl_valid,
    input  logic                  cmpl_ready,
    output logic [PID_WIDTH-1:0]  cmpl_pid,
    output logic [KID_WIDTH-1:0]  cmpl_kid,
    output logic [KERNEL_NUM-1:0] busy_vec
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT     = 2'd1;
    localparam logic [1:0] S_CAPTURE  = 2'd2;
    localparam logic [1:0] S_DISPATCH = 2'd3;
    localparam int PID_LSB = 992;
    localparam int ENTRY_W = KID_WIDTH + PID_WIDTH;
    localparam logic [KID_WIDTH-1:0] LAST = KID_WIDTH'(KERNEL_NUM - 1);

    logic [1:0]            state, state_nxt;
    logic [KERNEL_NUM-1:0] busy, busy_nxt, pend, pend_nxt;
    logic [KERNEL_NUM-1:0] free, done_ok, clr, disp_set;
    logic [KID_WIDTH-1:0]  sel_idx, tgt, push_kid;
    logic                  sel_ok, start_ok, push, pop;
    logic [PID_WIDTH-1:0]  pid_q;
    logic [PID_WIDTH-1:0]  pid_tab [KERNEL_NUM];
    logic                  proto_err;

    logic [ENTRY_W-1:0]    fifo_mem [KERNEL_NUM];
    logic [KID_WIDTH-1:0]  wr_ptr, rd_ptr;
    logic [KID_WIDTH:0]    count;

    assign free     = ~busy;
    assign busy_vec = busy;
    assign start_ok = engine_start && (state == S_IDLE) && (|free);
    assign done_ok  = kernel_done & busy & ~pend;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_ok) state_nxt = S_WAIT;
            S_WAIT:    state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_DISPATCH;
            default:   state_nxt = S_IDLE;
        endcase
    end

`ifdef KJD_ROUND_ROBIN_EN
    logic [KID_WIDTH-1:0] rr_ptr;
    int                   j;

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = '0;
        j       = 0;
        for (int i = KERNEL_NUM - 1; i >= 0; i--) begin
            j = (int'(rr_ptr) + i) % KERNEL_NUM;
            if (free[j]) begin
                sel_ok  = 1'b1;
                sel_idx = KID_WIDTH'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (state == S_CAPTURE && sel_ok)
            rr_ptr <= (sel_idx == LAST) ? '0 : sel_idx + 1'b1;
    end
`else
    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = '0;
        for (int i = KERNEL_NUM - 1; i >= 0; i--) begin
            if (free[i]) begin
                sel_ok  = 1'b1;
                sel_idx = KID_WIDTH'(i);
            end
        end
    end
`endif

    always_comb begin
        push     = |pend;
        push_kid = '0;
        for (int i = KERNEL_NUM - 1; i >= 0; i--)
            if (pend[i]) push_kid = KID_WIDTH'(i);
    end

    // A kernel freed while CAPTURE selects stays ineligible until next cycle.
    assign clr      = push ? (KERNEL_NUM'(1) << push_kid) : '0;
    assign disp_set = (state == S_DISPATCH) ? kernel_start : '0;
    assign busy_nxt = (busy | disp_set) & ~clr;
    assign pend_nxt = (pend & ~clr) | done_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            new_dsc      <= 1'b0;
            kernel_start <= '0;
            kernel_dsc   <= '0;
            pid_q        <= '0;
            tgt          <= '0;
            busy         <= '0;
            pend         <= '0;
            proto_err    <= 1'b0;
            for (int i = 0; i < KERNEL_NUM; i++) pid_tab[i] <= '0;
        end else begin
            state        <= state_nxt;
            new_dsc      <= (state_nxt == S_IDLE) && (|(~busy_nxt));
            busy         <= busy_nxt;
            pend         <= pend_nxt;
            kernel_start <= '0;
            if (state == S_CAPTURE) begin
                kernel_dsc <= system_register;
                pid_q      <= system_register[PID_LSB +: PID_WIDTH];
                tgt        <= sel_idx;
                if (sel_ok) kernel_start <= KERNEL_NUM'(1) << sel_idx;
            end
            if (state == S_DISPATCH && (|kernel_start))
                pid_tab[tgt] <= pid_q;
            if ((engine_start && !start_ok) || (|(kernel_done & ~busy)))
                proto_err <= 1'b1;
        end
    end

    assign pop        = cmpl_valid && cmpl_ready;
    assign cmpl_valid = (count != '0);
    assign {cmpl_kid, cmpl_pid} = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < KERNEL_NUM; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {push_kid, pid_tab[push_kid]};
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_kernel_job_dispatcher.sv
// Directed self-checking bench for kernel_job_dispatcher.
module tb_kernel_job_dispatcher;
    localparam int K  = 8;
    localparam int DW = 1024;

`ifdef KJD_ROUND_ROBIN_EN
    localparam logic [7:0] E6_START = 8'h20;
    localparam logic [7:0] E6_BUSY  = 8'h38;
    localparam logic [7:0] E7_START = 8'h40;
    localparam logic [7:0] CFG_B    = 8'h02;
`else
    localparam logic [7:0] E6_START = 8'h01;
    localparam logic [7:0] E6_BUSY  = 8'h19;
    localparam logic [7:0] E7_START = 8'h02;
    localparam logic [7:0] CFG_B    = 8'h01;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          engine_start;
    logic [DW-1:0] system_register;
    logic          new_dsc;
    logic [K-1:0]  kernel_start;
    logic [DW-1:0] kernel_dsc;
    logic [K-1:0]  kernel_done;
    logic          cmpl_valid;
    logic          cmpl_ready;
    logic [8:0]    cmpl_pid;
    logic [2:0]    cmpl_kid;
    logic [K-1:0]  busy_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kernel_job_dispatcher dut (
        .clk(clk), .rst_n(rst_n),
        .engine_start(engine_start),
        .system_register(system_register),
        .new_dsc(new_dsc),
        .kernel_start(kernel_start),
        .kernel_dsc(kernel_dsc),
        .kernel_done(kernel_done),
        .cmpl_valid(cmpl_valid),
        .cmpl_ready(cmpl_ready),
        .cmpl_pid(cmpl_pid),
        .cmpl_kid(cmpl_kid),
        .busy_vec(busy_vec)
    );

    typedef struct {
        logic [8:0] pid;
        logic [7:0] data;
        logic [7:0] exp_start;
        logic [7:0] exp_busy;
        logic       exp_new;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [8:0] pid,
                                         input logic [7:0] b);
        logic [DW-1:0] d;
        d = '0;
        d[7:0] = b;
        d[1000:992] = pid;
        return d;
    endfunction

    task automatic dispatch(input string tag, input logic [8:0] pid,
                            input logic [7:0] b, input logic [7:0] es,
                            input logic [7:0] eb, input logic en);
        @(negedge clk);
        chk({tag, ".new_pre"}, new_dsc, 1);
        engine_start = 1'b1;
        system_register = mk(pid, b);
        @(negedge clk);
        engine_start = 1'b0;
        chk({tag, ".new_t1"}, new_dsc, 0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, ".start"}, kernel_start, es);
        chk({tag, ".dsc_b"}, kernel_dsc[7:0], b);
        chk({tag, ".dsc_pid"}, kernel_dsc[1000:992], pid);
        chk({tag, ".new_t3"}, new_dsc, 0);
        @(negedge clk);
        chk({tag, ".start_t4"}, kernel_start, 0);
        chk({tag, ".busy"}, busy_vec, eb);
        chk({tag, ".new_t4"}, new_dsc, en);
    endtask

    task automatic pulse_done(input logic [7:0] d);
        @(negedge clk);
        kernel_done = d;
        @(negedge clk);
        kernel_done = '0;
    endtask

    logic [2:0] ek [3];
    logic [8:0] ep [3];

    initial begin
        vecs[0] = '{9'h005, 8'hA5, 8'h01, 8'h01, 1'b1};
        vecs[1] = '{9'h00A, 8'h3C, 8'h02, 8'h03, 1'b1};
        vecs[2] = '{9'h010, 8'h11, 8'h04, 8'h07, 1'b1};
        vecs[3] = '{9'h01F, 8'h22, 8'h08, 8'h0F, 1'b1};
        vecs[4] = '{9'h01E, 8'h33, 8'h10, 8'h1F, 1'b1};
        vecs[5] = '{9'h020, 8'h44, 8'h20, 8'h3F, 1'b1};
        vecs[6] = '{9'h02A, 8'h55, 8'h40, 8'h7F, 1'b1};
        vecs[7] = '{9'h030, 8'h66, 8'h80, 8'hFF, 1'b0};

        rst_n = 1'b1;
        engine_start = 1'b0;
        system_register = '0;
        kernel_done = '0;
        cmpl_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", busy_vec, 0);
        chk("rst.start", kernel_start, 0);
        chk("rst.dsc", kernel_dsc == '0, 1);
        chk("rst.valid", cmpl_valid, 0);
        chk("rst.pid", cmpl_pid, 0);
        chk("rst.kid", cmpl_kid, 0);
        chk("rst.new", new_dsc, 0);
        chk("rst.perr", dut.proto_err, 0);
        rst_n = 1'b1;
        #1 chk("rst.new_rel", new_dsc, 0);
        @(negedge clk);
        chk("rst.new_after", new_dsc, 1);

        for (int i = 0; i < 8; i++)
            dispatch($sformatf("fill%0d", i), vecs[i].pid, vecs[i].data,
                     vecs[i].exp_start, vecs[i].exp_busy, vecs[i].exp_new);
        repeat (3) @(negedge clk);
        chk("full.new_hold", new_dsc, 0);

        pulse_done(8'h08);
        chk("k3.busy_d1", busy_vec, 8'hFF);
        chk("k3.new_d1", new_dsc, 0);
        chk("k3.valid_d1", cmpl_valid, 0);
        @(negedge clk);
        chk("k3.new_d2", new_dsc, 1);
        chk("k3.busy_d2", busy_vec, 8'hF7);
        chk("k3.valid_d2", cmpl_valid, 1);
        chk("k3.kid", cmpl_kid, 3);
        chk("k3.pid", cmpl_pid, 9'h01F);
        cmpl_ready = 1'b1;
        @(negedge clk);
        cmpl_ready = 1'b0;
        chk("k3.popped", cmpl_valid, 0);
        dispatch("redo3", 9'h033, 8'h5A, 8'h08, 8'hFF, 1'b0);

        ek = '{3'd2, 3'd5, 3'd7};
        ep = '{9'h010, 9'h020, 9'h030};
        cmpl_ready = 1'b1;
        pulse_done(8'hA4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("sim%0d.valid", i), cmpl_valid, 1);
            chk($sformatf("sim%0d.kid", i), cmpl_kid, ek[i]);
            chk($sformatf("sim%0d.pid", i), cmpl_pid, ep[i]);
        end
        @(negedge clk);
        chk("sim.empty", cmpl_valid, 0);
        chk("sim.busy", busy_vec, 8'h5B);

        ek = '{3'd0, 3'd1, 3'd6};
        ep = '{9'h005, 9'h00A, 9'h02A};
        cmpl_ready = 1'b0;
        pulse_done(8'h43);
        @(negedge clk);
        chk("bp.valid", cmpl_valid, 1);
        chk("bp.kid", cmpl_kid, 0);
        repeat (3) @(negedge clk);
        cmpl_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("bp%0d.valid", i), cmpl_valid, 1);
            chk($sformatf("bp%0d.kid", i), cmpl_kid, ek[i]);
            chk($sformatf("bp%0d.pid", i), cmpl_pid, ep[i]);
        end
        @(negedge clk);
        chk("bp.empty", cmpl_valid, 0);
        chk("bp.busy", busy_vec, 8'h18);

        chk("perr.clean", dut.proto_err, 0);
        @(negedge clk);
        engine_start = 1'b1;
        system_register = mk(9'h044, 8'h77);
        @(negedge clk);
        chk("perr.new_t1", new_dsc, 0);
        @(negedge clk);
        engine_start = 1'b0;
        chk("perr.set", dut.proto_err, 1);
        @(negedge clk);
        chk("perr.start", kernel_start, E6_START);
        chk("perr.dsc_b", kernel_dsc[7:0], 8'h77);
        @(negedge clk);
        chk("perr.no_extra", kernel_start, 0);
        chk("perr.busy", busy_vec, E6_BUSY);
        chk("perr.new_t4", new_dsc, 1);

        @(negedge clk);
        engine_start = 1'b1;
        system_register = mk(9'h055, 8'h99);
        @(negedge clk);
        engine_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid.start", kernel_start, E7_START);
        rst_n = 1'b0;
        #1;
        chk("mid.start_rst", kernel_start, 0);
        chk("mid.busy_rst", busy_vec, 0);
        chk("mid.perr_rst", dut.proto_err, 0);
        chk("mid.new_rst", new_dsc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid.new_after", new_dsc, 1);

        dispatch("cfg_a", 9'h040, 8'h11, 8'h01, 8'h01, 1'b1);
        pulse_done(8'h01);
        @(negedge clk);
        chk("cfg.valid", cmpl_valid, 1);
        chk("cfg.kid", cmpl_kid, 0);
        chk("cfg.pid", cmpl_pid, 9'h040);
        @(negedge clk);
        chk("cfg.busy0", busy_vec, 0);
        dispatch("cfg_b", 9'h041, 8'h22, CFG_B, CFG_B, 1'b1);

        pulse_done(8'h10);
        chk("stale.perr", dut.proto_err, 1);
        @(negedge clk);
        chk("stale.valid", cmpl_valid, 0);
        chk("stale.busy", busy_vec, CFG_B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
